dma_external_device: RTL and testbench
======================================

# dma_external_device

Clocked, parametrised successor to the free-running external device model used by the TSC CPU DMA benches. Holds `NUM_BLOCKS` data blocks of `WORDS_PER_BLOCK` words each and raises a periodic `interrupt` to request a DMA transfer. It serves block reads by `offset` with a registered, validated response. After each completed transfer it refills its storage from an LFSR, or from a fixed pattern. It sits beside the CPU/DMA controller in the testbench as the I/O source.

## Interface
- `WORD_SIZE`, 16, bits per word
- `WORDS_PER_BLOCK`, 4, words returned per offset read
- `NUM_BLOCKS`, 3, number of addressable blocks (storage depth)
- `OFFSET_W`, 2, width of `offset`; must satisfy 2^OFFSET_W ≥ NUM_BLOCKS
- `FIRE_PERIOD`, 2600, idle cycles before each interrupt (≥1)
- `INT_CYCLES`, 100, interrupt high duration in cycles (≥1)
- `NUM_FIRES`, 2, interrupts generated before halting; 0 = unlimited
- `LFSR_SEED`, 16'hACE1, nonzero LFSR seed

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `offset`  in  OFFSET_W  block index to read
- `offset_valid`  in  1  read request strobe, one read per asserted cycle
- `dma_done`  in  1  one-cycle pulse from the DMA controller when the transfer has finished
- `interrupt`  out  1  DMA request to CPU
- `data`  out  WORDS_PER_BLOCK*WORD_SIZE  block read data; word k at `data[k*WORD_SIZE +: WORD_SIZE]`
- `data_valid`  out  1  `data` holds a valid block
- `offset_err`  out  1  read rejected (bad offset or wrong state)

## Operation
- FSM states: REFILL, IDLE, FIRE, XFER, HALT.
- REFILL
  - One word is written per cycle, block 0 word 0 first, word-major within each block.
  - The written word is the current LFSR state; the LFSR then advances.
  - Lasts NUM_BLOCKS*WORDS_PER_BLOCK cycles.
  - Exits to HALT if `fire_cnt` has reached a nonzero NUM_FIRES, else to IDLE.
- LFSR
  - 16-bit Fibonacci: `next = {s[14:0], s[15]^s[13]^s[12]^s[10]}`.
  - Word = LFSR state truncated or zero-extended to WORD_SIZE.
  - Never reloaded except by reset.
- IDLE
  - The down-counter is loaded with FIRE_PERIOD-1 on entry.
  - At 0 the FSM moves to FIRE and `fire_cnt` increments.
- FIRE
  - `interrupt`=1 for exactly INT_CYCLES cycles, then the FSM moves to XFER.
  - A `dma_done` during FIRE is latched and takes effect on entry to XFER.
- XFER
  - Waits for `dma_done`, then moves to REFILL.
  - The period counter does not run.
- HALT
  - Terminal state; only reset leaves it.
- Reads
  - Accepted in FIRE, XFER and HALT when `offset < NUM_BLOCKS`: next cycle `data` = storage[offset] and `data_valid`=1.
  - Otherwise: next cycle `offset_err`=1, `data_valid`=0, and `data` holds its previous value.
  - Reads in REFILL or IDLE are rejected.
  - With `offset_valid`=0, both `data_valid` and `offset_err` are 0 the following cycle.
- `dma_done` in REFILL, IDLE or HALT is ignored.

## Timing
- Reset values: `interrupt`=0, `data`=0, `data_valid`=0, `offset_err`=0, state=REFILL, LFSR=LFSR_SEED, `fire_cnt`=0.
- Reset mid-operation: `interrupt` drops immediately (asynchronous); storage contents are don't-care until the refill completes.
- Cycle numbering: cycle 1 is the first rising edge after `reset` deasserts.
  - REFILL occupies cycles 1..R, where R = NUM_BLOCKS*WORDS_PER_BLOCK.
  - `interrupt` is high in cycles R+FIRE_PERIOD+1 .. R+FIRE_PERIOD+INT_CYCLES.
- Read latency: 1 cycle. Back-to-back reads are supported at full rate.
- `dma_done` to the next interrupt: R refill cycles + FIRE_PERIOD cycles.

## Configuration
- `EXT_DEV_FIXED_PATTERN_EN`
  - Defined: REFILL writes 16'hC2C2 (truncated or replicated to WORD_SIZE) to every word; the LFSR is still present but unused.
  - Undefined: REFILL writes LFSR data as described above.
  - Refill timing is identical either way.

## Structure
- Shared package `ext_dev_pkg`:
  - FSM state enum
  - LFSR tap constant and the next-state function
  - fixed pattern constant 16'hC2C2
- One sub-module: `ext_dev_lfsr` (16-bit LFSR with seed parameter and advance enable).
- Storage is a register array, not a RAM macro; it is read combinationally into the output register.

## Test plan
- Reset release, default parameters → R=12. `interrupt` rises at cycle 2613 and falls after cycle 2712. No interrupt before that.
- Read offset 0 during FIRE, macro undefined → `data[15:0]`=16'hACE1, `data[31:16]`=16'h59C3, `data_valid`=1 one cycle later.
- Read offset 3 (≥ NUM_BLOCKS), and a read during IDLE → `offset_err`=1, `data_valid`=0, `data` unchanged.
- `dma_done` pulse in XFER → 12 refill cycles, a new interrupt FIRE_PERIOD cycles later. After the 2nd transfer and refill the block reaches HALT and never fires again.
- `EXT_DEV_FIXED_PATTERN_EN` defined → every read returns 64'hC2C2C2C2C2C2C2C2.
- `reset` asserted mid-FIRE → `interrupt` goes to 0 without waiting for a clock. After release the timeline of the first scenario repeats exactly.

Source files
------------

// File: rtl/ext_dev_pkg.sv
// Shared definitions for the DMA external device model: FSM states, LFSR taps/step, fixed fill pattern.
package ext_dev_pkg;

   localparam logic [2:0] ST_REFILL = 3'd0;
   localparam logic [2:0] ST_IDLE   = 3'd1;
   localparam logic [2:0] ST_FIRE   = 3'd2;
   localparam logic [2:0] ST_XFER   = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;

   // Taps at bits 15, 13, 12, 10 of the 16-bit Fibonacci LFSR.
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] FIXED_PATTERN = 16'hC2C2;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ext_dev_lfsr.sv
// 16-bit Fibonacci LFSR with reset seed; steps once per cycle while adv_i is high.
module ext_dev_lfsr
   import ext_dev_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        adv_i,
   output logic [15:0] state_o
);

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (adv_i) lfsr_d = lfsr_next(lfsr_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/dma_external_device.sv
// External I/O device model: refills block storage, raises periodic DMA interrupts, serves block reads.
// EXT_DEV_FIXED_PATTERN_EN selects a constant 16'hC2C2 fill instead of LFSR data.
module dma_external_device
   import ext_dev_pkg::*;
#(
   parameter int unsigned WORD_SIZE       = 16,
   parameter int unsigned WORDS_PER_BLOCK = 4,
   parameter int unsigned NUM_BLOCKS      = 3,
   parameter int unsigned OFFSET_W        = 2,
   parameter int unsigned FIRE_PERIOD     = 2600,
   parameter int unsigned INT_CYCLES      = 100,
   parameter int unsigned NUM_FIRES       = 2,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [OFFSET_W-1:0]                  offset,
   input  logic                                 offset_valid,
   input  logic                                 dma_done,
   output logic                                 interrupt,
   output logic [WORDS_PER_BLOCK*WORD_SIZE-1:0] data,
   output logic                                 data_valid,
   output logic                                 offset_err
);

   localparam int unsigned BLK_W   = WORDS_PER_BLOCK * WORD_SIZE;
   localparam int unsigned WRD_W   = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
   localparam int unsigned CNT_W   = 32;
   localparam int unsigned PAT_REP = (WORD_SIZE + 15) / 16;

   logic [2:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    fire_cnt_q, fire_cnt_d;
   logic [OFFSET_W-1:0] blk_q, blk_d;
   logic [WRD_W-1:0]    wrd_q, wrd_d;
   logic                done_pend_q, done_pend_d;
   logic                interrupt_q, interrupt_d;
   logic [BLK_W-1:0]    data_q, data_d;
   logic                data_valid_q, data_valid_d;
   logic                offset_err_q, offset_err_d;

   logic [BLK_W-1:0]     mem_q [NUM_BLOCKS];
   logic [15:0]          lfsr;
   logic [WORD_SIZE-1:0] fill_word;
   logic                 refill_c;
   logic                 last_word;
   logic                 rd_ok;

   ext_dev_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .adv_i   (refill_c),
      .state_o (lfsr)
   );

`ifdef EXT_DEV_FIXED_PATTERN_EN
   localparam logic [PAT_REP*16-1:0] PAT_WIDE = {PAT_REP{FIXED_PATTERN}};
   assign fill_word = WORD_SIZE'(PAT_WIDE);
`else
   assign fill_word = WORD_SIZE'(lfsr);
`endif

   assign last_word = (blk_q == OFFSET_W'(NUM_BLOCKS - 1)) &&
                      (wrd_q == WRD_W'(WORDS_PER_BLOCK - 1));

   // Sequencing: refill walk, idle countdown, interrupt window, wait for transfer completion.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fire_cnt_d  = fire_cnt_q;
      blk_d       = blk_q;
      wrd_d       = wrd_q;
      done_pend_d = done_pend_q;
      refill_c    = 1'b0;
      case (state_q)
         ST_REFILL: begin
            refill_c = 1'b1;
            if (wrd_q == WRD_W'(WORDS_PER_BLOCK - 1)) begin
               wrd_d = '0;
               blk_d = blk_q + 1'b1;
            end else begin
               wrd_d = wrd_q + 1'b1;
            end
            if (last_word) begin
               blk_d = '0;
               if ((NUM_FIRES != 0) && (fire_cnt_q >= CNT_W'(NUM_FIRES))) begin
                  state_d = ST_HALT;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = CNT_W'(FIRE_PERIOD - 1);
               end
            end
         end
         ST_IDLE: begin
            if (cnt_q == '0) begin
               state_d     = ST_FIRE;
               cnt_d       = CNT_W'(INT_CYCLES - 1);
               fire_cnt_d  = fire_cnt_q + 1'b1;
               done_pend_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_FIRE: begin
            // An early completion is remembered and honoured once XFER is entered.
            if (dma_done) done_pend_d = 1'b1;
            if (cnt_q == '0) state_d = ST_XFER;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_XFER: begin
            if (dma_done || done_pend_q) begin
               state_d     = ST_REFILL;
               done_pend_d = 1'b0;
            end
         end
         ST_HALT: begin
         end
         default: state_d = ST_REFILL;
      endcase
   end

   assign rd_ok = offset_valid &&
                  ((state_q == ST_FIRE) || (state_q == ST_XFER) || (state_q == ST_HALT)) &&
                  (CNT_W'(offset) < CNT_W'(NUM_BLOCKS));

   always_comb begin
      interrupt_d  = (state_q == ST_FIRE);
      data_d       = data_q;
      data_valid_d = rd_ok;
      offset_err_d = offset_valid && !rd_ok;
      if (rd_ok) data_d = mem_q[offset];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_REFILL;
         cnt_q        <= '0;
         fire_cnt_q   <= '0;
         blk_q        <= '0;
         wrd_q        <= '0;
         done_pend_q  <= 1'b0;
         interrupt_q  <= 1'b0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         offset_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fire_cnt_q   <= fire_cnt_d;
         blk_q        <= blk_d;
         wrd_q        <= wrd_d;
         done_pend_q  <= done_pend_d;
         interrupt_q  <= interrupt_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         offset_err_q <= offset_err_d;
      end
   end

   // Storage has no reset; its contents are only meaningful after a refill.
   always_ff @(posedge clk) begin
      if (refill_c) mem_q[blk_q][wrd_q*WORD_SIZE +: WORD_SIZE] <= fill_word;
   end

   assign interrupt  = interrupt_q;
   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign offset_err = offset_err_q;

endmodule

// File: tb/tb_dma_external_device.sv
// Self-checking bench for dma_external_device: timeline, reads, transfers, halt and async reset.
module tb_dma_external_device;

   localparam int unsigned WS  = 16;
   localparam int unsigned WPB = 4;
   localparam int unsigned NB  = 3;
   localparam int unsigned OW  = 2;
   localparam int unsigned FP  = 2600;
   localparam int unsigned IC  = 100;
   localparam int unsigned NF  = 2;
   localparam int          R   = NB * WPB;
   localparam logic [15:0] SEED = 16'hACE1;
`ifdef EXT_DEV_FIXED_PATTERN_EN
   localparam logic [15:0] W0_EXP = 16'hC2C2;
   localparam logic [15:0] W1_EXP = 16'hC2C2;
`else
   localparam logic [15:0] W0_EXP = 16'hACE1;
   localparam logic [15:0] W1_EXP = 16'h59C3;
`endif

   logic            clk;
   logic            reset;
   logic [OW-1:0]   offset;
   logic            offset_valid;
   logic            dma_done;
   logic            interrupt;
   logic [WPB*WS-1:0] data;
   logic            data_valid;
   logic            offset_err;

   int checks;
   int errors;
   int cyc;

   logic [15:0] lfsr_m;
   logic [63:0] blk_m [NB];
   logic [63:0] data_m;

   dma_external_device #(
      .WORD_SIZE(WS), .WORDS_PER_BLOCK(WPB), .NUM_BLOCKS(NB), .OFFSET_W(OW),
      .FIRE_PERIOD(FP), .INT_CYCLES(IC), .NUM_FIRES(NF), .LFSR_SEED(SEED)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .offset       (offset),
      .offset_valid (offset_valid),
      .dma_done     (dma_done),
      .interrupt    (interrupt),
      .data         (data),
      .data_valid   (data_valid),
      .offset_err   (offset_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference storage: each refill takes the next R LFSR states, block-major, word-major.
   task automatic model_refill();
      for (int b = 0; b < int'(NB); b++) begin
         for (int k = 0; k < int'(WPB); k++) begin
`ifdef EXT_DEV_FIXED_PATTERN_EN
            blk_m[b][k*16 +: 16] = 16'hC2C2;
`else
            blk_m[b][k*16 +: 16] = lfsr_m;
`endif
            lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
         end
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
      cyc = 0;
      lfsr_m = SEED;
      model_refill();
      data_m = '0;
   endtask

   // Runs until cycle c_end relative to event edge t0, checking interrupt and read responses every cycle.
   task automatic run_phase(input int t0, input int c_end, input int done_at, input bit halted,
                            input string tag);
      int rel;
      logic exp_int;
      logic [65:0] exp_resp;
      logic [65:0] got;
      logic [OW-1:0] off;
      bit rej_zone;
      bit acc_zone;
      exp_resp = {2'b00, data_m};
      while (cyc < c_end) begin
         step();
         rel = cyc - t0;
         exp_int = !halted && (rel >= R + int'(FP) + 1) && (rel <= R + int'(FP) + int'(IC));
         checks++;
         if (interrupt !== exp_int) begin
            errors++;
            $display("FAIL %s_interrupt cyc=%0d got=%b required=%b", tag, cyc, interrupt, exp_int);
         end
         got = {data_valid, offset_err, data};
         checks++;
         if (got !== exp_resp) begin
            errors++;
            $display("FAIL %s_read cyc=%0d got=%h required=%h", tag, cyc, got, exp_resp);
         end
         offset_valid = 1'b0;
         dma_done = 1'b0;
         exp_resp = {2'b00, data_m};
         if (cyc < c_end) begin
            if (rel == done_at) dma_done = 1'b1;
            rej_zone = (rel >= 1 && rel <= R - 2) ||
                       (!halted && rel >= R + 1 && rel <= R + int'(FP) - 2);
            acc_zone = halted ? (rel >= R + 1) : (rel >= R + int'(FP) + 2);
            if ((rej_zone || acc_zone) && $urandom_range(0, 5) == 0) begin
               off = OW'($urandom_range(0, 3));
               offset = off;
               offset_valid = 1'b1;
               if (acc_zone && off < NB) begin
                  data_m = blk_m[off];
                  exp_resp = {2'b10, data_m};
               end else begin
                  exp_resp = {2'b01, data_m};
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      offset = '0;
      offset_valid = 1'b0;
      dma_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({interrupt, data_valid, offset_err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got=%b required=000", {interrupt, data_valid, offset_err});
      end
      checks++;
      if (data !== '0) begin
         errors++;
         $display("FAIL reset_data got=%h required=0", data);
      end
      release_reset();
   endtask

   task automatic test_read_fire();
      offset = 2'd0;
      offset_valid = 1'b1;
      step();
      checks++;
      if ({data_valid, offset_err} !== 2'b10) begin
         errors++;
         $display("FAIL fire_read0_flags got=%b required=10", {data_valid, offset_err});
      end
      checks++;
      if (data[15:0] !== W0_EXP) begin
         errors++;
         $display("FAIL fire_read0_word0 got=%h required=%h", data[15:0], W0_EXP);
      end
      checks++;
      if (data[31:16] !== W1_EXP) begin
         errors++;
         $display("FAIL fire_read0_word1 got=%h required=%h", data[31:16], W1_EXP);
      end
      checks++;
      if (data !== blk_m[0]) begin
         errors++;
         $display("FAIL fire_read0_block got=%h required=%h", data, blk_m[0]);
      end
      data_m = blk_m[0];
      offset = 2'd3;
      step();
      checks++;
      if ({data_valid, offset_err, data} !== {2'b01, data_m}) begin
         errors++;
         $display("FAIL bad_offset got=%b/%h required=01/%h", {data_valid, offset_err}, data, data_m);
      end
      offset_valid = 1'b0;
      step();
      checks++;
      if ({data_valid, offset_err} !== 2'b00) begin
         errors++;
         $display("FAIL no_request_flags got=%b required=00", {data_valid, offset_err});
      end
   endtask

   task automatic test_back_to_back();
      logic [OW-1:0] o;
      for (int i = 0; i < 8; i++) begin
         o = OW'($urandom_range(0, NB - 1));
         offset = o;
         offset_valid = 1'b1;
         step();
         data_m = blk_m[o];
         checks++;
         if ({data_valid, offset_err, data} !== {2'b10, data_m}) begin
            errors++;
            $display("FAIL b2b_read%0d off=%0d got=%b/%h required=10/%h",
                     i, o, {data_valid, offset_err}, data, data_m);
         end
      end
      offset_valid = 1'b0;
      step();
      checks++;
      if ({data_valid, offset_err} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_idle_flags got=%b required=00", {data_valid, offset_err});
      end
   endtask

   task automatic test_first_fire();
      run_phase(0, R + int'(FP) + 30, R + 100, 1'b0, "first");
      test_read_fire();
      test_back_to_back();
      run_phase(0, R + int'(FP) + int'(IC) + 6, -1, 1'b0, "first_tail");
   endtask

   // Transfer 1 completes in XFER; transfer 2's completion arrives early, during FIRE.
   task automatic test_dma_transfers(output int e2);
      int e;
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;
      e = cyc;
      model_refill();
      e2 = e + R + int'(FP) + int'(IC) + 1;
      run_phase(e, e2, R + int'(FP) + 20, 1'b0, "second");
   endtask

   task automatic test_halt(input int e2);
      model_refill();
      run_phase(e2, e2 + R + int'(FP) + int'(IC) + 50, R + 20, 1'b1, "halt");
   endtask

   task automatic test_reset_mid_fire();
      reset = 1'b1;
      @(posedge clk);
      release_reset();
      run_phase(0, R + int'(FP) + 40, -1, 1'b0, "pre_reset");
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({interrupt, data_valid, offset_err} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset got=%b required=000", {interrupt, data_valid, offset_err});
      end
      @(posedge clk);
      release_reset();
      run_phase(0, R + int'(FP) + int'(IC) + 5, -1, 1'b0, "after_reset");
   endtask

   initial begin
      int e2;
      checks = 0;
      errors = 0;
      cyc = 0;
      test_reset();
      test_first_fire();
      test_dma_transfers(e2);
      test_halt(e2);
      test_reset_mid_fire();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
